// File: rtl/ex_mem_lsu_if.sv
// Data-RAM request/response bus between the load/store unit (master) and the RAM (slave).
// One request per access: req is held until addr_ok, then a single data_ok returns read data or write ack.
interface ex_mem_lsu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  wr;
    logic [DATA_WIDTH-1:0] addr;
    logic [3:0]            wstrb;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  addr_ok;
    logic                  data_ok;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, wr, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/ex_mem_lsu.sv
// EX->MEM pipeline stage with a one-transaction-per-instruction data-RAM load/store unit.
// Load data is lane-selected and extended before it is handed to WB.
//
// state | meaning
// IDLE  | no RAM access pending (empty stage, non-memory op or misaligned access)
// REQ   | request presented, waiting for dram addr_ok
// WAIT  | request accepted, waiting for dram data_ok
// DONE  | access complete, result held until WB takes it
module ex_mem_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  hold,
    input  logic                  valid_ex,
    input  logic                  ready_go_ex,
    output logic                  allow_in_mem,
    input  logic [DATA_WIDTH-1:0] alu_result_ex,
    input  logic [DATA_WIDTH-1:0] rs2_data_ex,
    input  logic [RD_WIDTH-1:0]   rd_ex,
    input  logic                  reg_write_ex,
    input  logic [4:0]            mem_ctrl_ex,
    output logic                  valid_mem,
    output logic                  ready_go_mem,
    input  logic                  allow_in_wb,
    output logic [DATA_WIDTH-1:0] result_mem,
    output logic [RD_WIDTH-1:0]   rd_mem,
    output logic                  reg_write_mem,
    output logic                  misalign_mem,
    ex_mem_lsu_if.master          dram
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CTRL_LOAD  = 4;
    localparam int CTRL_STORE = 3;
    localparam int CTRL_UNS   = 2;

    state_t                state;
    state_t                state_nxt;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [RD_WIDTH-1:0]   rd_q;
    logic                  reg_write_q;
    logic [4:0]            ctrl_q;

    logic                  pipe_valid;
    logic                  mem_in;
    logic                  mis_in;
    logic                  mem_q;
    logic                  mis_q;
    logic [DATA_WIDTH-1:0] load_fmt;
    logic [3:0]            strb_fmt;
    logic [DATA_WIDTH-1:0] wdata_fmt;

    // Size 3 is treated as a word access everywhere.
    function automatic logic is_misaligned(input logic [4:0] ctrl, input logic [1:0] a);
        logic mem_op;
        mem_op = ctrl[CTRL_LOAD] | ctrl[CTRL_STORE];
        if (ctrl[1])
            return mem_op & (a != 2'b00);
        else if (ctrl[0])
            return mem_op & a[0];
        else
            return 1'b0;
    endfunction

    assign pipe_valid = valid_ex & ready_go_ex & ~flush;
    assign mem_in     = mem_ctrl_ex[CTRL_LOAD] | mem_ctrl_ex[CTRL_STORE];
    assign mis_in     = is_misaligned(mem_ctrl_ex, alu_result_ex[1:0]);
    assign mem_q      = ctrl_q[CTRL_LOAD] | ctrl_q[CTRL_STORE];
    assign mis_q      = is_misaligned(ctrl_q, addr_q[1:0]);

    assign ready_go_mem  = valid_q & ((state == DONE) | ~mem_q | mis_q);
    assign allow_in_mem  = ~valid_q | (ready_go_mem & allow_in_wb & ~hold);
    assign valid_mem     = valid_q;
    assign result_mem    = result_q;
    assign rd_mem        = rd_q;
    assign reg_write_mem = valid_q & reg_write_q & ~mis_q;
    assign misalign_mem  = valid_q & mis_q;

    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        load_fmt = '0;
        unique case (addr_q[1:0])
            2'd0:    byte_sel = dram.rdata[7:0];
            2'd1:    byte_sel = dram.rdata[15:8];
            2'd2:    byte_sel = dram.rdata[23:16];
            default: byte_sel = dram.rdata[31:24];
        endcase
        half_sel = addr_q[1] ? dram.rdata[31:16] : dram.rdata[15:0];
        if (ctrl_q[1])
            load_fmt = dram.rdata;
        else if (ctrl_q[0])
            load_fmt = {{(DATA_WIDTH-16){half_sel[15] & ~ctrl_q[CTRL_UNS]}}, half_sel};
        else
            load_fmt = {{(DATA_WIDTH-8){byte_sel[7] & ~ctrl_q[CTRL_UNS]}}, byte_sel};
    end

    always_comb begin
        strb_fmt  = 4'b0000;
        wdata_fmt = '0;
        if (ctrl_q[1]) begin
            strb_fmt  = 4'b1111;
            wdata_fmt = wdata_q;
        end else if (ctrl_q[0]) begin
            strb_fmt  = 4'b0011 << addr_q[1:0];
            wdata_fmt = {2{wdata_q[15:0]}};
        end else begin
            strb_fmt  = 4'b0001 << addr_q[1:0];
            wdata_fmt = {4{wdata_q[7:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            result_q    <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            ctrl_q      <= '0;
        end else begin
            state <= state_nxt;
            if (allow_in_mem)
                valid_q <= pipe_valid;
            if (pipe_valid && allow_in_mem) begin
                addr_q      <= alu_result_ex;
                wdata_q     <= rs2_data_ex;
                result_q    <= alu_result_ex;
                rd_q        <= rd_ex;
                reg_write_q <= reg_write_ex;
                ctrl_q      <= mem_ctrl_ex;
            end else if (state == WAIT && dram.data_ok && ctrl_q[CTRL_LOAD]) begin
                result_q <= load_fmt;
            end
        end
    end

    // A memory op holds allow_in_mem low until DONE, so the accepted request is never dropped.
    always_comb begin
        state_nxt   = state;
        dram.req    = 1'b0;
        dram.wr     = 1'b0;
        dram.addr   = '0;
        dram.wstrb  = 4'b0000;
        dram.wdata  = '0;
        unique case (state)
            REQ: begin
                dram.req  = 1'b1;
                dram.wr   = ctrl_q[CTRL_STORE];
                dram.addr = {addr_q[DATA_WIDTH-1:2], 2'b00};
                if (ctrl_q[CTRL_STORE]) begin
                    dram.wstrb = strb_fmt;
                    dram.wdata = wdata_fmt;
                end
                if (dram.addr_ok)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (dram.data_ok)
                    state_nxt = DONE;
            end
            default: ;
        endcase
        if (allow_in_mem)
            state_nxt = (pipe_valid && mem_in && !mis_in) ? REQ : IDLE;
    end

endmodule

// File: tb/tb_ex_mem_lsu.sv
// Directed bench for ex_mem_lsu: a vector table of single instructions with a simple RAM responder,
// plus hand-written sequences for delayed addr_ok, WB back-pressure, hold, flush and mid-access reset.
module tb_ex_mem_lsu;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        hold;
    logic        valid_ex;
    logic        ready_go_ex;
    logic        allow_in_mem;
    logic [31:0] alu_result_ex;
    logic [31:0] rs2_data_ex;
    logic [4:0]  rd_ex;
    logic        reg_write_ex;
    logic [4:0]  mem_ctrl_ex;
    logic        valid_mem;
    logic        ready_go_mem;
    logic        allow_in_wb;
    logic [31:0] result_mem;
    logic [4:0]  rd_mem;
    logic        reg_write_mem;
    logic        misalign_mem;

    ex_mem_lsu_if #(.DATA_WIDTH(32)) dram ();

    ex_mem_lsu #(.DATA_WIDTH(32), .RD_WIDTH(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .hold          (hold),
        .valid_ex      (valid_ex),
        .ready_go_ex   (ready_go_ex),
        .allow_in_mem  (allow_in_mem),
        .alu_result_ex (alu_result_ex),
        .rs2_data_ex   (rs2_data_ex),
        .rd_ex         (rd_ex),
        .reg_write_ex  (reg_write_ex),
        .mem_ctrl_ex   (mem_ctrl_ex),
        .valid_mem     (valid_mem),
        .ready_go_mem  (ready_go_mem),
        .allow_in_wb   (allow_in_wb),
        .result_mem    (result_mem),
        .rd_mem        (rd_mem),
        .reg_write_mem (reg_write_mem),
        .misalign_mem  (misalign_mem),
        .dram          (dram.master)
    );

    localparam logic [4:0] C_ALU = 5'b00000;
    localparam logic [4:0] C_LB  = 5'b10000;
    localparam logic [4:0] C_LBU = 5'b10100;
    localparam logic [4:0] C_LH  = 5'b10001;
    localparam logic [4:0] C_LHU = 5'b10101;
    localparam logic [4:0] C_LW  = 5'b10010;
    localparam logic [4:0] C_SB  = 5'b01000;
    localparam logic [4:0] C_SH  = 5'b01001;
    localparam logic [4:0] C_SW  = 5'b01010;

    typedef struct {
        string       name;
        logic [4:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        regw;
        logic [31:0] rdata;
        int          exp_reqs;
        logic        exp_wr;
        logic [31:0] exp_daddr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_dwdata;
        logic [31:0] exp_result;
        logic        exp_mis;
        logic        exp_regw;
    } vec_t;

    vec_t vecs[11];
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout waiting for DUT", name);
    endtask

    task automatic drive_instr(input logic [4:0] ctrl, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [4:0] rd, input logic regw);
        valid_ex      = 1'b1;
        ready_go_ex   = 1'b1;
        mem_ctrl_ex   = ctrl;
        alu_result_ex = addr;
        rs2_data_ex   = wd;
        rd_ex         = rd;
        reg_write_ex  = regw;
    endtask

    task automatic run_vec(input vec_t v);
        int          reqs;
        bit          pend;
        bit          done;
        logic        s_wr;
        logic [31:0] s_addr;
        logic [3:0]  s_strb;
        logic [31:0] s_wdata;
        reqs = 0; pend = 0; done = 0;
        s_wr = 0; s_addr = 0; s_strb = 0; s_wdata = 0;
        @(negedge clk);
        chk({v.name, " allow_in"}, {31'd0, allow_in_mem}, 32'd1);
        drive_instr(v.ctrl, v.addr, v.wdata, v.rd, v.regw);
        @(negedge clk);
        valid_ex = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (c > 0) @(negedge clk);
            dram.addr_ok = 1'b0;
            dram.data_ok = 1'b0;
            if (ready_go_mem) begin
                done = 1;
                chk({v.name, " valid"},  {31'd0, valid_mem}, 32'd1);
                chk({v.name, " result"}, result_mem, v.exp_result);
                chk({v.name, " rd"},     {27'd0, rd_mem}, {27'd0, v.rd});
                chk({v.name, " regw"},   {31'd0, reg_write_mem}, {31'd0, v.exp_regw});
                chk({v.name, " mis"},    {31'd0, misalign_mem}, {31'd0, v.exp_mis});
            end else if (dram.req) begin
                if (reqs == 0) begin
                    s_wr = dram.wr; s_addr = dram.addr; s_strb = dram.wstrb; s_wdata = dram.wdata;
                end
                reqs++;
                dram.addr_ok = 1'b1;
                pend = 1;
            end else if (pend) begin
                dram.data_ok = 1'b1;
                dram.rdata   = v.rdata;
                pend = 0;
            end
        end
        dram.addr_ok = 1'b0;
        dram.data_ok = 1'b0;
        if (!done) timeout({v.name, " ready_go"});
        chk({v.name, " reqs"}, reqs, v.exp_reqs);
        if (v.exp_reqs > 0) begin
            chk({v.name, " wr"},    {31'd0, s_wr}, {31'd0, v.exp_wr});
            chk({v.name, " daddr"}, s_addr, v.exp_daddr);
            chk({v.name, " wstrb"}, {28'd0, s_strb}, {28'd0, v.exp_wstrb});
            chk({v.name, " wdata"}, s_wdata, v.exp_dwdata);
        end
    endtask

    initial begin
        int          reqs;
        bit          pend;
        bit          done;
        checks = 0;
        errors = 0;
        rst = 1'b1; flush = 1'b0; hold = 1'b0; allow_in_wb = 1'b1;
        valid_ex = 1'b0; ready_go_ex = 1'b0; alu_result_ex = 0; rs2_data_ex = 0;
        rd_ex = 0; reg_write_ex = 0; mem_ctrl_ex = 0;
        dram.addr_ok = 1'b0; dram.data_ok = 1'b0; dram.rdata = 0;

        // name ctrl addr wdata rd regw rdata | reqs wr daddr wstrb dwdata result mis regw
        vecs[0]  = '{"alu",   C_ALU, 32'h0000_1234, 32'h0,          5'd5,  1'b1, 32'h0,
                     0, 1'b0, 32'h0,   4'b0000, 32'h0,          32'h0000_1234, 1'b0, 1'b1};
        vecs[1]  = '{"lb",    C_LB,  32'h0000_0103, 32'h0,          5'd6,  1'b1, 32'h80FF_FF11,
                     1, 1'b0, 32'h100, 4'b0000, 32'h0,          32'hFFFF_FF80, 1'b0, 1'b1};
        vecs[2]  = '{"lbu",   C_LBU, 32'h0000_0103, 32'h0,          5'd7,  1'b1, 32'h80FF_FF11,
                     1, 1'b0, 32'h100, 4'b0000, 32'h0,          32'h0000_0080, 1'b0, 1'b1};
        vecs[3]  = '{"lb0",   C_LB,  32'h0000_0100, 32'h0,          5'd8,  1'b1, 32'h0000_007F,
                     1, 1'b0, 32'h100, 4'b0000, 32'h0,          32'h0000_007F, 1'b0, 1'b1};
        vecs[4]  = '{"lh",    C_LH,  32'h0000_0102, 32'h0,          5'd9,  1'b1, 32'h8001_1234,
                     1, 1'b0, 32'h100, 4'b0000, 32'h0,          32'hFFFF_8001, 1'b0, 1'b1};
        vecs[5]  = '{"lhu",   C_LHU, 32'h0000_0102, 32'h0,          5'd10, 1'b1, 32'h8001_1234,
                     1, 1'b0, 32'h100, 4'b0000, 32'h0,          32'h0000_8001, 1'b0, 1'b1};
        vecs[6]  = '{"lw",    C_LW,  32'h0000_0204, 32'h0,          5'd11, 1'b1, 32'hDEAD_BEEF,
                     1, 1'b0, 32'h204, 4'b0000, 32'h0,          32'hDEAD_BEEF, 1'b0, 1'b1};
        vecs[7]  = '{"sb",    C_SB,  32'h0000_0101, 32'h1234_5655,  5'd0,  1'b0, 32'h0,
                     1, 1'b1, 32'h100, 4'b0010, 32'h5555_5555,  32'h0000_0101, 1'b0, 1'b0};
        vecs[8]  = '{"sw",    C_SW,  32'h0000_0104, 32'h1234_5678,  5'd0,  1'b0, 32'h0,
                     1, 1'b1, 32'h104, 4'b1111, 32'h1234_5678,  32'h0000_0104, 1'b0, 1'b0};
        vecs[9]  = '{"sw_mis", C_SW, 32'h0000_0101, 32'h1111_2222,  5'd0,  1'b0, 32'h0,
                     0, 1'b0, 32'h0,   4'b0000, 32'h0,          32'h0000_0101, 1'b1, 1'b0};
        vecs[10] = '{"lh_mis", C_LH, 32'h0000_0101, 32'h0,          5'd12, 1'b1, 32'h0,
                     0, 1'b0, 32'h0,   4'b0000, 32'h0,          32'h0000_0101, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst valid",    {31'd0, valid_mem},    32'd0);
        chk("rst req",      {31'd0, dram.req},     32'd0);
        chk("rst allow_in", {31'd0, allow_in_mem}, 32'd1);
        chk("rst result",   result_mem,            32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // SH with addr_ok withheld for three request cycles
        @(negedge clk);
        drive_instr(C_SH, 32'h0000_0102, 32'h0000_ABCD, 5'd0, 1'b0);
        @(negedge clk);
        valid_ex = 1'b0;
        reqs = 0; pend = 0; done = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (c > 0) @(negedge clk);
            dram.addr_ok = 1'b0;
            dram.data_ok = 1'b0;
            if (ready_go_mem) begin
                done = 1;
            end else if (dram.req) begin
                reqs++;
                chk("sh wstrb", {28'd0, dram.wstrb}, 32'h0000_000C);
                chk("sh wdata", dram.wdata, 32'hABCD_ABCD);
                if (reqs == 4) begin
                    dram.addr_ok = 1'b1;
                    pend = 1;
                end
            end else if (pend) begin
                dram.data_ok = 1'b1;
                pend = 0;
            end
        end
        dram.addr_ok = 1'b0;
        dram.data_ok = 1'b0;
        if (!done) timeout("sh ready_go");
        chk("sh reqs", reqs, 4);

        // LW completes while WB refuses for five cycles; a waiting ALU op enters afterwards
        @(negedge clk);
        allow_in_wb = 1'b0;
        drive_instr(C_LW, 32'h0000_0300, 32'h0, 5'd13, 1'b1);
        @(negedge clk);
        valid_ex = 1'b0;
        reqs = 0; pend = 0; done = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (c > 0) @(negedge clk);
            dram.addr_ok = 1'b0;
            dram.data_ok = 1'b0;
            if (ready_go_mem) done = 1;
            else if (dram.req) begin reqs++; dram.addr_ok = 1'b1; pend = 1; end
            else if (pend) begin dram.data_ok = 1'b1; dram.rdata = 32'hCAFE_F00D; pend = 0; end
        end
        dram.addr_ok = 1'b0;
        dram.data_ok = 1'b0;
        if (!done) timeout("bp ready_go");
        drive_instr(C_ALU, 32'h0000_0077, 32'h0, 5'd3, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            if (dram.req) reqs++;
            chk("bp allow_in", {31'd0, allow_in_mem}, 32'd0);
            chk("bp result",   result_mem, 32'hCAFE_F00D);
        end
        chk("bp reqs", reqs, 1);
        allow_in_wb = 1'b1;
        @(negedge clk);
        valid_ex = 1'b0;
        chk("bp next valid",  {31'd0, valid_mem}, 32'd1);
        chk("bp next result", result_mem, 32'h0000_0077);
        chk("bp next rd",     {27'd0, rd_mem}, 32'd3);

        // hold freezes hand-off of a finished ALU op
        hold = 1'b1;
        @(negedge clk);
        chk("hold valid",    {31'd0, valid_mem},    32'd1);
        chk("hold allow_in", {31'd0, allow_in_mem}, 32'd0);
        hold = 1'b0;
        @(negedge clk);
        chk("hold release", {31'd0, valid_mem}, 32'd0);

        // flushed instruction never enters the stage
        drive_instr(C_LW, 32'h0000_0400, 32'h0, 5'd14, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        valid_ex = 1'b0;
        flush = 1'b0;
        chk("flush valid", {31'd0, valid_mem}, 32'd0);
        chk("flush req",   {31'd0, dram.req},  32'd0);

        // reset while a request is outstanding
        drive_instr(C_LW, 32'h0000_0500, 32'h0, 5'd15, 1'b1);
        @(negedge clk);
        valid_ex = 1'b0;
        chk("mid req", {31'd0, dram.req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst req",   {31'd0, dram.req},  32'd0);
        chk("mid rst valid", {31'd0, valid_mem}, 32'd0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
